scmp_microcode_seq: RTL
=======================

Name: scmp_microcode_seq

Overview:
- Microcode sequencer: owns the microcode program counter (uPC) and consumes the per-opcode entry label (op_pc) produced by the opcode dispatch decoder.
- Each cycle it selects the next uPC from the current microcode word's sequencing field: sequential, dispatch, jump, conditional jump, call or return.
- Stalls on unacknowledged bus cycles, inserts pending interrupts at instruction dispatch, and provides a one-level microcode subroutine return register.
- Its uPC output addresses the microcode ROM.

Parameters:
UPC_W, 6, width of uPC; must equal $bits(NEXTPC_t), enforced by elaboration-time assertion

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
op_pc  in  NEXTPC_t  entry label from opcode dispatch decoder for the current opcode
uc_seq  in  SEQ_t (3)  sequencing field of current microcode word
uc_target  in  NEXTPC_t  jump/call target field of current microcode word
uc_cond  in  1  evaluated branch condition for CJMP
uc_bus_req  in  1  current microcode word starts a bus cycle
bus_ack  in  1  bus cycle complete this cycle
ie  in  1  interrupt-enable flag
sa_int  in  1  interrupt request (sense A), already synchronised
upc  out  NEXTPC_t  current microcode address
stall  out  1  uPC held this cycle (combinational)
dispatch  out  1  one-cycle pulse: opcode dispatch taken
int_ack  out  1  one-cycle pulse: dispatch redirected to interrupt entry
uc_err  out  1  one-cycle pulse: return-stack misuse

Behaviour:
- Reset (async, rst=1): upc=UCLBL_FETCH; ret_reg=UCLBL_FETCH; ret_valid=0; int_pend=0; dispatch=int_ack=uc_err=0.
- stall = uc_bus_req & ~bus_ack. While stall=1:
  - all state is held and every pulse output is 0;
  - int_pend may still set.
  - Stall has priority over every sequencing action.
- int_pend <= (int_pend | (sa_int & ie)) & ~int_ack_next. A new request arriving in the same cycle as a redirect is not lost if sa_int is still high next cycle.
- Next-uPC, registered (one-cycle latency from uc_seq to upc), when not stalled:
  - SEQ: upc+1, modulo 2^UPC_W (wraps to 0).
  - DISPATCH:
    - if int_pend: upc=UCLBL_INT, int_ack=1, int_pend cleared;
    - else upc=op_pc.
    - dispatch=1 in both cases.
  - JMP: upc=uc_target.
  - CJMP: uc_cond ? uc_target : upc+1.
  - CALL:
    - ret_reg=upc+1, ret_valid=1, upc=uc_target;
    - if ret_valid was already 1, overwrite and pulse uc_err.
  - RET:
    - if ret_valid: upc=ret_reg, ret_valid=0;
    - else upc=UCLBL_FETCH and pulse uc_err.
  - Undefined SEQ_t codes: upc=UCLBL_FETCH and pulse uc_err.
- Pulses (dispatch, int_ack, uc_err) are registered, asserted in the cycle after the deciding edge, one cycle wide.
- sa_int with ie=0: ignored, but int_pend once set persists even if ie later drops. Microcode clears IE on entry to UCLBL_INT.
- Reset mid-stall or mid-subroutine: immediately returns to reset values; no residual pending interrupt.

Decomposition:
- scmp_microcode_pak gains:
  - SEQ_t enum: SEQ=0, DISPATCH=1, JMP=2, CJMP=3, CALL=4, RET=5;
  - UCLBL_INT entry label.
- NEXTPC_t and UCLBL_* labels stay in the package.
- No sub-module; next-uPC mux and state register live in one always_comb/always_ff pair.

Test Plan:
- Reset released with uc_seq=SEQ -> upc=UCLBL_FETCH at reset, then UCLBL_FETCH+1, +2 on successive edges.
- uc_seq=DISPATCH, op_pc=UCLBL_LD, int_pend=0 -> upc=UCLBL_LD next cycle, dispatch pulses once, int_ack=0.
- ie=1, sa_int=1 for one cycle, then DISPATCH with op_pc=UCLBL_ST -> upc=UCLBL_INT, int_ack=1; a following DISPATCH with sa_int=0 -> upc=op_pc.
- uc_bus_req=1, bus_ack=0 for 3 cycles with uc_seq=JMP, uc_target=5 -> upc frozen and stall=1 for 3 cycles; bus_ack=1 -> upc=5.
- upc=10, CALL target 20 -> upc=20; later RET -> upc=11; second RET -> upc=UCLBL_FETCH, uc_err=1.
- upc=2^UPC_W-1 with SEQ -> upc=0. CJMP with uc_cond=0 at upc=7 -> 8; with uc_cond=1 -> uc_target.

Source files
------------

// File: rtl/scmp_microcode_pak.sv
// Shared microcode types: uPC label type, entry labels and the sequencing-field encoding.
package scmp_microcode_pak;

  localparam int unsigned NEXTPC_W = 6;

  typedef logic [NEXTPC_W-1:0] NEXTPC_t;

  typedef enum logic [2:0] {
    SEQ      = 3'd0,
    DISPATCH = 3'd1,
    JMP      = 3'd2,
    CJMP     = 3'd3,
    CALL     = 3'd4,
    RET      = 3'd5
  } SEQ_t;

  localparam NEXTPC_t UCLBL_FETCH = 6'd0;
  localparam NEXTPC_t UCLBL_LD    = 6'd16;
  localparam NEXTPC_t UCLBL_ST    = 6'd24;
  localparam NEXTPC_t UCLBL_INT   = 6'd48;

endpackage

// File: rtl/scmp_microcode_seq.sv
// Microcode sequencer: owns the uPC, selects the next address from the sequencing field,
// stalls on bus cycles, redirects dispatch to the interrupt entry, one-level call/return.
module scmp_microcode_seq
  import scmp_microcode_pak::*;
#(
  parameter int unsigned UPC_W = 6
) (
  input  logic    clk,
  input  logic    rst,
  input  NEXTPC_t op_pc,
  input  SEQ_t    uc_seq,
  input  NEXTPC_t uc_target,
  input  logic    uc_cond,
  input  logic    uc_bus_req,
  input  logic    bus_ack,
  input  logic    ie,
  input  logic    sa_int,
  output NEXTPC_t upc,
  output logic    stall,
  output logic    dispatch,
  output logic    int_ack,
  output logic    uc_err
);

  if (UPC_W != $bits(NEXTPC_t)) begin : g_upc_w_check
    $fatal(1, "UPC_W must equal the width of NEXTPC_t");
  end

  NEXTPC_t r_upc, r_ret;
  logic    r_ret_valid, r_int_pend, r_dispatch, r_int_ack, r_uc_err;

  NEXTPC_t w_upc_d, w_ret_d, w_upc_inc;
  logic    w_ret_valid_d, w_int_pend_d, w_dispatch_d, w_int_ack_d, w_uc_err_d;
  logic    w_stall;

  assign w_stall   = uc_bus_req & ~bus_ack;
  assign w_upc_inc = NEXTPC_t'(r_upc + NEXTPC_t'(1));

  always_comb begin
    w_upc_d       = r_upc;
    w_ret_d       = r_ret;
    w_ret_valid_d = r_ret_valid;
    w_dispatch_d  = 1'b0;
    w_int_ack_d   = 1'b0;
    w_uc_err_d    = 1'b0;
    if (!w_stall) begin
      case (uc_seq)
        SEQ:      w_upc_d = w_upc_inc;
        DISPATCH: begin
          w_dispatch_d = 1'b1;
          if (r_int_pend) begin
            w_upc_d     = UCLBL_INT;
            w_int_ack_d = 1'b1;
          end else begin
            w_upc_d = op_pc;
          end
        end
        JMP:      w_upc_d = uc_target;
        CJMP:     w_upc_d = uc_cond ? uc_target : w_upc_inc;
        CALL: begin
          // A live return address is overwritten; flag the lost frame.
          w_ret_d       = w_upc_inc;
          w_ret_valid_d = 1'b1;
          w_upc_d       = uc_target;
          w_uc_err_d    = r_ret_valid;
        end
        RET: begin
          if (r_ret_valid) begin
            w_upc_d       = r_ret;
            w_ret_valid_d = 1'b0;
          end else begin
            w_upc_d    = UCLBL_FETCH;
            w_uc_err_d = 1'b1;
          end
        end
        default: begin
          w_upc_d    = UCLBL_FETCH;
          w_uc_err_d = 1'b1;
        end
      endcase
    end
  end

  // Pending interrupt may latch while stalled; only a taken redirect clears it.
  assign w_int_pend_d = (r_int_pend | (sa_int & ie)) & ~w_int_ack_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_upc       <= UCLBL_FETCH;
      r_ret       <= UCLBL_FETCH;
      r_ret_valid <= 1'b0;
      r_int_pend  <= 1'b0;
      r_dispatch  <= 1'b0;
      r_int_ack   <= 1'b0;
      r_uc_err    <= 1'b0;
    end else begin
      r_upc       <= w_upc_d;
      r_ret       <= w_ret_d;
      r_ret_valid <= w_ret_valid_d;
      r_int_pend  <= w_int_pend_d;
      r_dispatch  <= w_dispatch_d;
      r_int_ack   <= w_int_ack_d;
      r_uc_err    <= w_uc_err_d;
    end
  end

  assign upc      = r_upc;
  assign stall    = w_stall;
  assign dispatch = r_dispatch;
  assign int_ack  = r_int_ack;
  assign uc_err   = r_uc_err;

endmodule
